// File: rtl/dma_bus_master_if.sv
// Bus bundle for the DMA engine: configuration slave port plus the m1 master port.
// The master modport is the DMA's view; the slave modport is the bus/arbiter side.
interface dma_bus_master_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
);
  logic              s_sel;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_din;
  logic [DATA_W-1:0] s_dout;

  logic              m_req;
  logic              m_grant;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic [DATA_W-1:0] m_din;

  modport master (
    input  s_sel, s_wr, s_addr, s_din, m_grant, m_din,
    output s_dout, m_req, m_wr, m_addr, m_dout
  );

  modport slave (
    output s_sel, s_wr, s_addr, s_din, m_grant, m_din,
    input  s_dout, m_req, m_wr, m_addr, m_dout
  );
endinterface

// File: rtl/dma_bus_master.sv
// Single-channel memory-to-memory DMA: copies SIZE words from SRC to DST over the
// arbitrated master port, configured through a small register slave port.
module dma_bus_master #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  dma_bus_master_if.master bus,
  output logic             irq
);

  typedef enum logic [2:0] {StIdle, StReq, StRd, StCap, StWr, StDone} state_e;

  localparam logic [7:0] OffSrc    = 8'h00;
  localparam logic [7:0] OffDst    = 8'h01;
  localparam logic [7:0] OffSize   = 8'h02;
  localparam logic [7:0] OffStart  = 8'h03;
  localparam logic [7:0] OffInt    = 8'h04;
  localparam logic [7:0] OffIntEn  = 8'h05;
  localparam logic [7:0] OffStatus = 8'h06;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  size_q, size_d;
  logic [CNT_W-1:0]  index_q, index_d, index_inc;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              done_q, done_d;
  logic              int_en_q, int_en_d;
  logic              irq_q, irq_d;

  logic              wr_en, rd_en, start_wr, set_done, busy;
  logic [7:0]        off;
  logic              m_req, m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;

  assign off       = bus.s_addr[7:0];
  assign wr_en     = bus.s_sel & bus.s_wr;
  assign rd_en     = bus.s_sel & ~bus.s_wr;
  assign busy      = state_q inside {StReq, StRd, StCap, StWr};
  assign start_wr  = wr_en && (off == OffStart) && bus.s_din[0] && !busy;
  assign index_inc = index_q + CNT_W'(1);

  // Transfer sequencer; any cycle without grant is dropped and retried from REQ.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    buf_d    = buf_q;
    set_done = 1'b0;
    m_req    = 1'b0;
    m_wr     = 1'b0;
    m_addr   = '0;
    m_dout   = '0;
    case (state_q)
      StIdle: begin
        if (start_wr) begin
          if (size_q != '0) begin
            index_d = '0;
            state_d = StReq;
          end else begin
            set_done = 1'b1;
          end
        end
      end
      StReq: begin
        m_req = 1'b1;
        if (bus.m_grant) state_d = StRd;
      end
      StRd: begin
        m_req   = 1'b1;
        m_addr  = src_q + ADDR_W'(index_q);
        state_d = bus.m_grant ? StCap : StReq;
      end
      StCap: begin
        m_req  = 1'b1;
        m_addr = src_q + ADDR_W'(index_q);
        if (bus.m_grant) begin
          buf_d   = bus.m_din;
          state_d = StWr;
        end else begin
          state_d = StReq;
        end
      end
      StWr: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_q + ADDR_W'(index_q);
        m_dout = buf_q;
        if (bus.m_grant) begin
          index_d = index_inc;
          state_d = (index_inc == size_q) ? StDone : StRd;
        end else begin
          state_d = StReq;
        end
      end
      StDone: begin
        set_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Register file writes; transfer setup is frozen while a copy is in flight.
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    size_d   = size_q;
    int_en_d = int_en_q;
    done_d   = done_q;
    if (wr_en) begin
      case (off)
        OffSrc:   if (!busy) src_d = bus.s_din[ADDR_W-1:0];
        OffDst:   if (!busy) dst_d = bus.s_din[ADDR_W-1:0];
        OffSize:  if (!busy) size_d = bus.s_din[CNT_W-1:0];
        OffInt:   if (!bus.s_din[0]) done_d = 1'b0;
        OffIntEn: int_en_d = bus.s_din[0];
        default:  ;
      endcase
    end
    // A completion on the same edge as a software clear must not be lost.
    if (set_done) done_d = 1'b1;
    irq_d = done_d & int_en_d;
  end

  always_comb begin
    dout_d = '0;
    if (rd_en) begin
      case (off)
        OffSrc:    dout_d = DATA_W'(src_q);
        OffDst:    dout_d = DATA_W'(dst_q);
        OffSize:   dout_d = DATA_W'(size_q);
        OffInt:    dout_d = DATA_W'(done_q);
        OffIntEn:  dout_d = DATA_W'(int_en_q);
        OffStatus: dout_d = DATA_W'(busy);
        default:   dout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      src_q    <= '0;
      dst_q    <= '0;
      size_q   <= '0;
      index_q  <= '0;
      buf_q    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      int_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      size_q   <= size_d;
      index_q  <= index_d;
      buf_q    <= buf_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      int_en_q <= int_en_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.s_dout = dout_q;
  assign bus.m_req  = m_req;
  assign bus.m_wr   = m_wr;
  assign bus.m_addr = m_addr;
  assign bus.m_dout = m_dout;
  assign irq        = irq_q;

  // Writes only happen inside an owned tenure, and a parked master drives a quiet bus.
  assert property (@(posedge clk) disable iff (!reset_n) m_wr |-> m_req);
  assert property (@(posedge clk) disable iff (!reset_n)
                   !m_req |-> (m_addr == '0 && m_dout == '0));

endmodule

// File: tb/tb_dma_bus_master.sv
// Bench for dma_bus_master: register table, directed multi-cycle sequences and
// randomized copies checked against a word-by-word copy model.
module tb_dma_bus_master;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic irq;

  dma_bus_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  dma_bus_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  logic [31:0] mem [0:65535];
  logic [47:0] wlog [$];
  logic [47:0] exp_log [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          req_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock; the memory model commits granted writes and serves m_din.
  task automatic step();
    bit          do_wr;
    logic [15:0] wa;
    logic [31:0] wd;
    do_wr = bus_if.m_wr && bus_if.m_grant;
    wa    = bus_if.m_addr;
    wd    = bus_if.m_dout;
    if (bus_if.m_req) req_seen = 1'b1;
    @(posedge clk);
    #1;
    if (do_wr) begin
      mem[wa] = wd;
      wlog.push_back({wa, wd});
    end
    bus_if.m_din = mem[bus_if.m_addr];
  endtask

  task automatic reg_write(input logic [15:0] addr, input logic [31:0] data);
    bus_if.s_sel  = 1'b1;
    bus_if.s_wr   = 1'b1;
    bus_if.s_addr = addr;
    bus_if.s_din  = data;
    step();
    bus_if.s_sel  = 1'b0;
    bus_if.s_wr   = 1'b0;
  endtask

  task automatic reg_read(input logic [15:0] addr, output logic [31:0] data);
    bus_if.s_sel  = 1'b1;
    bus_if.s_wr   = 1'b0;
    bus_if.s_addr = addr;
    step();
    data          = bus_if.s_dout;
    bus_if.s_sel  = 1'b0;
  endtask

  task automatic wait_irq(input string name, input int bound);
    int n = 0;
    while (irq !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk({name, "_irq"}, {31'd0, irq}, 32'd1);
  endtask

  // Reference: sequential word copy, later reads see earlier writes of the same copy.
  task automatic build_exp(input logic [15:0] src, input logic [15:0] dst, input int size);
    logic [31:0] ov [logic [15:0]];
    exp_log.delete();
    for (int i = 0; i < size; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      logic [31:0] v;
      a = src + 16'(i);
      d = dst + 16'(i);
      v = ov.exists(a) ? ov[a] : mem[a];
      ov[d] = v;
      exp_log.push_back({d, v});
    end
  endtask

  task automatic compare_log(input string name);
    int bad = 0;
    chk({name, "_nwrites"}, 32'(wlog.size()), 32'(exp_log.size()));
    for (int i = 0; i < wlog.size() && i < exp_log.size(); i++)
      if (wlog[i] !== exp_log[i]) bad++;
    chk({name, "_wdata_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    reg_vec_t    vecs [11];
    logic [31:0] r;
    int          wr_mask, req_mask, irq_mask;

    reset_n        = 1'b0;
    bus_if.s_sel   = 1'b0;
    bus_if.s_wr    = 1'b0;
    bus_if.s_addr  = '0;
    bus_if.s_din   = '0;
    bus_if.m_grant = 1'b0;
    bus_if.m_din   = '0;
    req_seen       = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;

    #3;
    chk("rst_s_dout", bus_if.s_dout, 32'd0);
    chk("rst_m_req", {31'd0, bus_if.m_req}, 32'd0);
    chk("rst_m_addr", {16'd0, bus_if.m_addr}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    #9 reset_n = 1'b1;
    step();

    // Register access table: write then read back the same offset.
    vecs[0]  = '{16'h0000, 32'hABCD_1234, 32'h0000_1234};
    vecs[1]  = '{16'h0100, 32'h0000_0010, 32'h0000_0010};
    vecs[2]  = '{16'h0001, 32'h0000_0020, 32'h0000_0020};
    vecs[3]  = '{16'h0002, 32'h0000_01FF, 32'h0000_00FF};
    vecs[4]  = '{16'h0002, 32'h0000_0003, 32'h0000_0003};
    vecs[5]  = '{16'h0005, 32'h0000_0001, 32'h0000_0001};
    vecs[6]  = '{16'h0007, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[7]  = '{16'h0003, 32'h0000_0000, 32'h0000_0000};
    vecs[8]  = '{16'h0006, 32'h0000_0001, 32'h0000_0000};
    vecs[9]  = '{16'h0004, 32'h0000_0001, 32'h0000_0000};
    vecs[10] = '{16'h01FF, 32'h0000_0001, 32'h0000_0000};
    for (int i = 0; i < 11; i++) begin
      reg_write(vecs[i].addr, vecs[i].wdata);
      reg_read(vecs[i].addr, r);
      chk($sformatf("reg_vec%0d", i), r, vecs[i].exp);
    end
    step();
    chk("s_dout_idle_zero", bus_if.s_dout, 32'd0);

    // Basic copy: SRC=0x10, DST=0x20, SIZE=3, INT_EN=1, continuous grant.
    mem[16'h0010] = 32'hA5A5_0001;
    mem[16'h0011] = 32'hB6B6_0002;
    mem[16'h0012] = 32'hC7C7_0003;
    bus_if.m_grant = 1'b1;
    wlog.delete();
    build_exp(16'h0010, 16'h0020, 3);
    reg_write(16'h0003, 32'd1);
    wr_mask  = 0;
    req_mask = bus_if.m_req ? 1 : 0;
    irq_mask = 0;
    for (int rel = 1; rel <= 11; rel++) begin
      step();
      if (bus_if.m_wr) wr_mask |= (1 << rel);
      if (bus_if.m_req) req_mask |= (1 << rel);
      if (irq) irq_mask |= (1 << rel);
      if (rel == 1) chk("copy_rd0_addr", {16'd0, bus_if.m_addr}, 32'h10);
      if (rel == 3) begin
        chk("copy_wr0_addr", {16'd0, bus_if.m_addr}, 32'h20);
        chk("copy_wr0_data", bus_if.m_dout, 32'hA5A5_0001);
      end
    end
    chk("copy_wr_cycles", 32'(wr_mask), 32'h248);
    chk("copy_req_cycles", 32'(req_mask), 32'h3FF);
    chk("copy_irq_cycles", 32'(irq_mask), 32'h800);
    compare_log("copy");
    chk("copy_mem22", mem[16'h0022], 32'hC7C7_0003);

    // SIZE=0: done on the start edge, no bus request.
    reg_write(16'h0004, 32'd0);
    chk("clr_irq", {31'd0, irq}, 32'd0);
    reg_write(16'h0002, 32'd0);
    req_seen = 1'b0;
    reg_write(16'h0003, 32'd1);
    chk("size0_irq", {31'd0, irq}, 32'd1);
    repeat (3) step();
    chk("size0_no_req", {31'd0, req_seen}, 32'd0);
    reg_read(16'h0004, r);
    chk("size0_done", r, 32'd1);

    // Grant loss during CAP of word 1 for four cycles.
    reg_write(16'h0004, 32'd0);
    reg_write(16'h0000, 32'h40);
    reg_write(16'h0001, 32'h50);
    reg_write(16'h0002, 32'd3);
    mem[16'h0040] = 32'h1111_000D;
    mem[16'h0041] = 32'h2222_000E;
    mem[16'h0042] = 32'h3333_000F;
    wlog.delete();
    build_exp(16'h0040, 16'h0050, 3);
    reg_write(16'h0003, 32'd1);
    repeat (5) step();
    chk("gl_cap1_addr", {16'd0, bus_if.m_addr}, 32'h41);
    bus_if.m_grant = 1'b0;
    step();
    chk("gl_req_wait", {31'd0, bus_if.m_req}, 32'd1);
    chk("gl_req_addr", {16'd0, bus_if.m_addr}, 32'd0);
    repeat (3) step();
    bus_if.m_grant = 1'b1;
    step();
    chk("gl_reread_addr", {16'd0, bus_if.m_addr}, 32'h41);
    wait_irq("gl", 40);
    compare_log("gl");

    // Busy protection: SRC write and START mid-transfer are ignored.
    reg_write(16'h0004, 32'd0);
    reg_write(16'h0000, 32'h60);
    reg_write(16'h0001, 32'h70);
    reg_write(16'h0002, 32'd4);
    wlog.delete();
    build_exp(16'h0060, 16'h0070, 4);
    reg_write(16'h0003, 32'd1);
    repeat (3) step();
    reg_write(16'h0000, 32'h99);
    reg_write(16'h0003, 32'd1);
    reg_read(16'h0006, r);
    chk("busy_status", r, 32'd1);
    wait_irq("busy", 60);
    req_seen = 1'b0;
    reg_read(16'h0000, r);
    chk("busy_src_kept", r, 32'h60);
    repeat (5) step();
    chk("busy_no_restart", {31'd0, req_seen}, 32'd0);
    compare_log("busy");
    reg_write(16'h0004, 32'd0);
    chk("busy_irq_clr", {31'd0, irq}, 32'd0);
    reg_read(16'h0004, r);
    chk("busy_done_clr", r, 32'd0);

    // Reset asserted asynchronously during WR, with irq pending.
    reg_write(16'h0002, 32'd0);
    reg_write(16'h0003, 32'd1);
    reg_write(16'h0002, 32'd2);
    reg_write(16'h0003, 32'd1);
    repeat (3) step();
    chk("rstm_in_wr", {31'd0, bus_if.m_wr}, 32'd1);
    chk("rstm_irq_pre", {31'd0, irq}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstm_m_req", {31'd0, bus_if.m_req}, 32'd0);
    chk("rstm_m_wr", {31'd0, bus_if.m_wr}, 32'd0);
    chk("rstm_m_addr", {16'd0, bus_if.m_addr}, 32'd0);
    chk("rstm_irq", {31'd0, irq}, 32'd0);
    #10 reset_n = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      reg_read(16'(i), r);
      chk($sformatf("rstm_reg%0d", i), r, 32'd0);
    end

    // Randomized copies with random grant; first trial wraps and overlaps.
    for (int t = 0; t < 12; t++) begin
      logic [15:0] src;
      logic [15:0] dst;
      int          size;
      int          n;
      logic        ie;
      src  = (t == 0) ? 16'hFFFE : 16'($urandom);
      dst  = (t == 0) ? 16'hFFFD : 16'($urandom);
      size = (t == 0) ? 5 : int'($urandom_range(0, 10));
      ie   = 1'($urandom_range(0, 1));
      reg_write(16'h0004, 32'd0);
      reg_write(16'h0000, {16'd0, src});
      reg_write(16'h0001, {16'd0, dst});
      reg_write(16'h0002, 32'(size));
      reg_write(16'h0005, {31'd0, ie});
      build_exp(src, dst, size);
      wlog.delete();
      req_seen = 1'b0;
      reg_write(16'h0003, 32'd1);
      n = 0;
      r = '0;
      while (r[0] !== 1'b1 && n < 1500) begin
        bus_if.m_grant = ($urandom_range(0, 9) < 7);
        reg_read(16'h0004, r);
        n++;
      end
      chk($sformatf("rnd%0d_done", t), {31'd0, r[0]}, 32'd1);
      compare_log($sformatf("rnd%0d", t));
      chk($sformatf("rnd%0d_irq", t), {31'd0, irq}, {31'd0, ie});
      if (size == 0) chk($sformatf("rnd%0d_no_req", t), {31'd0, req_seen}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
